// File: rtl/sram_scan_ctrl.sv
// Scan-chain SRAM test controller: shifts in a command word, turns a global strobe into a
// one-cycle macro access, and reloads captured read data for scan-out. Option: SRAM_SCAN_ERR_EN.
module sram_scan_ctrl #(
    parameter int SEL_W      = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int NUM_MACROS = 12,
    parameter int CHAIN_W    = SEL_W + 2 * (ADDR_W + DATA_W + 6)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scan_en,
    input  logic                         scan_in,
    output logic                         scan_out,
    input  logic                         sram_load,
    input  logic                         global_csb,
    output logic [SEL_W-1:0]             sel_o,
    output logic [NUM_MACROS-1:0]        csb0_o,
    output logic [NUM_MACROS-1:0]        csb1_o,
    output logic                         web0_o,
    output logic                         web1_o,
    output logic [3:0]                   wmask0_o,
    output logic [3:0]                   wmask1_o,
    output logic [ADDR_W-1:0]            addr0_o,
    output logic [ADDR_W-1:0]            addr1_o,
    output logic [DATA_W-1:0]            din0_o,
    output logic [DATA_W-1:0]            din1_o,
    input  logic [NUM_MACROS*DATA_W-1:0] dout0_i,
    input  logic [NUM_MACROS*DATA_W-1:0] dout1_i,
    output logic                         err_o
);
    localparam int PORT_W     = ADDR_W + DATA_W + 6;
    localparam int WMASK1_LSB = 0;
    localparam int WEB1_POS   = 4;
    localparam int CSB1_POS   = 5;
    localparam int DIN1_LSB   = 6;
    localparam int ADDR1_LSB  = DIN1_LSB + DATA_W;
    localparam int WMASK0_LSB = PORT_W;
    localparam int WEB0_POS   = PORT_W + 4;
    localparam int CSB0_POS   = PORT_W + 5;
    localparam int DIN0_LSB   = PORT_W + 6;
    localparam int ADDR0_LSB  = DIN0_LSB + DATA_W;
    localparam int SEL_LSB    = 2 * PORT_W;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    logic [CHAIN_W-1:0]    chain_q, chain_d;
    state_t                state_q, state_d;
    logic                  gcsb_q, gcsb_d;
    logic [NUM_MACROS-1:0] csb0_q, csb0_d, csb1_q, csb1_d;
    logic                  cap_rd0_q, cap_rd0_d, cap_rd1_q, cap_rd1_d;
    logic [SEL_W-1:0]      acc_sel_q, acc_sel_d;
    logic [DATA_W-1:0]     dout0_q, dout0_d, dout1_q, dout1_d;

    logic [SEL_W-1:0]  sel_f;
    logic              csb0_f, web0_f, csb1_f, web1_f;
    logic              sel_ok, strobe;
    logic [DATA_W-1:0] rd0, rd1;

    assign sel_f  = chain_q[SEL_LSB +: SEL_W];
    assign csb0_f = chain_q[CSB0_POS];
    assign web0_f = chain_q[WEB0_POS];
    assign csb1_f = chain_q[CSB1_POS];
    assign web1_f = chain_q[WEB1_POS];
    assign sel_ok = 32'(sel_f) < 32'(NUM_MACROS);

    // Falling edge of the strobe; a coincident shift or load wins and the edge is lost.
    assign strobe = !global_csb && gcsb_q && (state_q == IDLE) && !scan_en && !sram_load;

    // Select latched at the strobe so a shift during the access cannot move the capture.
    always_comb begin
        rd0 = '0;
        rd1 = '0;
        for (int k = 0; k < NUM_MACROS; k++) begin
            if (acc_sel_q == SEL_W'(k)) begin
                rd0 = dout0_i[k*DATA_W +: DATA_W];
                rd1 = dout1_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        chain_d   = chain_q;
        state_d   = state_q;
        gcsb_d    = global_csb;
        csb0_d    = csb0_q;
        csb1_d    = csb1_q;
        cap_rd0_d = cap_rd0_q;
        cap_rd1_d = cap_rd1_q;
        acc_sel_d = acc_sel_q;
        dout0_d   = dout0_q;
        dout1_d   = dout1_q;

        if (scan_en) begin
            chain_d = {chain_q[CHAIN_W-2:0], scan_in};
        end else if (sram_load && (state_q == IDLE)) begin
            if (cap_rd0_q) chain_d[DIN0_LSB +: DATA_W] = dout0_q;
            if (cap_rd1_q) chain_d[DIN1_LSB +: DATA_W] = dout1_q;
        end

        case (state_q)
            IDLE: begin
                if (strobe) begin
                    state_d   = ACCESS;
                    acc_sel_d = sel_f;
                    cap_rd0_d = sel_ok && !csb0_f && web0_f;
                    cap_rd1_d = sel_ok && !csb1_f && web1_f;
                    for (int k = 0; k < NUM_MACROS; k++) begin
                        csb0_d[k] = !(sel_ok && (sel_f == SEL_W'(k)) && !csb0_f);
                        csb1_d[k] = !(sel_ok && (sel_f == SEL_W'(k)) && !csb1_f);
                    end
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
                csb0_d  = '1;
                csb1_d  = '1;
            end
            CAPTURE: begin
                state_d = IDLE;
                if (cap_rd0_q) dout0_d = rd0;
                if (cap_rd1_q) dout1_d = rd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q   <= '0;
            state_q   <= IDLE;
            gcsb_q    <= 1'b1;
            csb0_q    <= '1;
            csb1_q    <= '1;
            cap_rd0_q <= 1'b0;
            cap_rd1_q <= 1'b0;
            acc_sel_q <= '0;
            dout0_q   <= '0;
            dout1_q   <= '0;
        end else begin
            chain_q   <= chain_d;
            state_q   <= state_d;
            gcsb_q    <= gcsb_d;
            csb0_q    <= csb0_d;
            csb1_q    <= csb1_d;
            cap_rd0_q <= cap_rd0_d;
            cap_rd1_q <= cap_rd1_d;
            acc_sel_q <= acc_sel_d;
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
        end
    end

`ifdef SRAM_SCAN_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (strobe & ~sel_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign scan_out = chain_q[CHAIN_W-1];
    assign sel_o    = sel_f;
    assign csb0_o   = csb0_q;
    assign csb1_o   = csb1_q;
    assign web0_o   = web0_f;
    assign web1_o   = web1_f;
    assign wmask0_o = chain_q[WMASK0_LSB +: 4];
    assign wmask1_o = chain_q[WMASK1_LSB +: 4];
    assign addr0_o  = chain_q[ADDR0_LSB +: ADDR_W];
    assign addr1_o  = chain_q[ADDR1_LSB +: ADDR_W];
    assign din0_o   = chain_q[DIN0_LSB +: DATA_W];
    assign din1_o   = chain_q[DIN1_LSB +: DATA_W];

endmodule

// File: doc/sram_scan_ctrl.md
# sram_scan_ctrl

- Serial scan-chain controller that sits between the GPIO test pins (scan clock, data-in, scan-enable, load, global strobe) and the SRAM macro array under test.
- Shifts in a 112-bit command word and converts a global strobe into a single-cycle macro access on the selected macro.
- Captures read data and loads it back into the chain so it can be scanned out on the data-out pin.

## Interface

Parameters:
- SEL_W, 4, macro select field width
- ADDR_W, 16, address field width per port
- DATA_W, 32, data field width per port
- NUM_MACROS, 12, number of macros attached; valid sel values are 0..NUM_MACROS-1
- CHAIN_W, SEL_W+2*(ADDR_W+DATA_W+6), derived, 112 at defaults

Ports:
- clk  in  1  scan/SRAM clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- scan_en  in  1  shift enable
- scan_in  in  1  serial data in
- scan_out  out  1  serial data out = chain[CHAIN_W-1]
- sram_load  in  1  parallel-load captured read data into chain
- global_csb  in  1  active-low access strobe
- sel_o  out  SEL_W  sel field
- csb0_o, csb1_o  out  NUM_MACROS each  per-macro active-low chip selects, registered
- web0_o, web1_o  out  1  write-enable-bar fields
- wmask0_o, wmask1_o  out  4  write-mask fields
- addr0_o, addr1_o  out  ADDR_W  address fields
- din0_o, din1_o  out  DATA_W  write-data fields
- dout0_i, dout1_i  in  NUM_MACROS*DATA_W  flattened read data, macro k at [k*DATA_W +: DATA_W]
- err_o  out  1  sticky invalid-select flag

## Operation

- Chain layout, MSB to LSB: sel, addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1.
- Non-csb field outputs are driven combinationally from the chain.
- Priority per cycle: scan_en > sram_load > strobe.
- scan_en=1: chain <= {chain[CHAIN_W-2:0], scan_in}.
  - The first bit shifted lands in the MSB after CHAIN_W shifts.
  - scan_out presents chain MSB before the first shift edge.
- Strobe detect: gcsb_q registers global_csb (reset value 1). A falling edge is global_csb=0 && gcsb_q=1, and counts only in IDLE with scan_en=0. All other strobes are ignored.
- FSM states: IDLE, ACCESS, CAPTURE.
  - IDLE -> ACCESS on a detected strobe:
    - csb0_o[sel] <= csb0 field; csb1_o[sel] <= csb1 field; every other bit stays 1.
    - cap_rd0 <= (csb0==0 && web0==1); cap_rd1 likewise.
  - ACCESS -> CAPTURE unconditionally; all csb_o <= 1.
  - CAPTURE -> IDLE unconditionally:
    - dout_q0 <= dout0_i slice[sel] if cap_rd0, else dout_q0 holds.
    - dout_q1 is handled the same way from dout1_i and cap_rd1.
- sram_load=1 in IDLE with scan_en=0: din0 field <= dout_q0 if cap_rd0, and din1 field <= dout_q1 if cap_rd1. All other chain bits are unchanged. sram_load in ACCESS or CAPTURE is ignored.
- sel >= NUM_MACROS at a strobe: no csb asserted, no capture (cap_rd cleared), err_o set.
- Reset, including mid-access: chain=0, dout_q=0, cap_rd=0, csb*_o all 1, err_o=0, state IDLE, scan_out=0. Fields therefore show web=0, wmask=0, addr=0, din=0, but are inert because every csb is 1.

## Timing

- E0: rising edge sampling the strobe. csb_o is low for exactly one cycle (E0..E1) and the macro samples at E1.
- Read data must be valid before E2. It is captured at E2, and the FSM is back in IDLE after E2.
- The earliest sram_load honored is the one sampled at E3. The earliest scan-out shift of loaded data is E4.
- Strobe-to-strobe minimum spacing: 3 cycles. A global_csb held low for several cycles produces one access.
- Full command shift: CHAIN_W cycles. Full readback: CHAIN_W-1 shift edges, since bit 111 is visible before shifting.

## Configuration

- SRAM_SCAN_ERR_EN defined: invalid-select detection and sticky err_o are active as above.
- Undefined: err_o is tied 0. An out-of-range sel still asserts no csb and captures nothing.

## Test plan

- Reset: assert rst mid-ACCESS -> all csb*_o=1 immediately, err_o=0, scan_out=0, chain reads back all zeros.
- Shift: scan 112 bits with sel=2, addr0=1, din0=0x00000002, csb0=0, web0=0 -> sel_o=2, addr0_o=1, din0_o=2. After the strobe, csb0_o=12'hFFB for exactly one cycle and csb1_o=12'hFFF.
- Read loop: with macro 3 dout0_i slice=0xDEADBEEF and csb0=0, web0=1, addr0=1 -> strobe, then sram_load at E3. Scan-out equals the command word with din0=0xDEADBEEF and din1 unchanged.
- Dual-port read: csb0=0, csb1=0, web0=web1=1, dout0=5, dout1=0xFFFFFFFA -> both din fields replaced on load. With csb1=1, din1 is kept at 0.
- Ignore rules: strobe while scan_en=1 -> no csb pulse. sram_load sampled at E2 -> chain unchanged. global_csb held low 5 cycles -> one csb pulse.
- Invalid select: sel=15 with NUM_MACROS=12 -> no csb pulse. err_o=1 (stays 1 until rst) when SRAM_SCAN_ERR_EN is defined, else 0.
